// File: rtl/dm_cmd_arbiter.sv
// dm_cmd_arbiter: round-robin sharing of one DataMover command channel with completion routing and timeout
module dm_cmd_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_src_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr,
  input  logic [NUM_REQ*32-1:0]         req_btt,
  input  logic [NUM_REQ-1:0]            req_is_read,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [NUM_REQ-1:0]            req_err,
  input  logic                          cmd_ready,
  output logic                          cmd_start,
  output logic [ADDR_WIDTH-1:0]         cmd_src_addr,
  output logic [ADDR_WIDTH-1:0]         cmd_dst_addr,
  output logic [31:0]                   cmd_btt,
  output logic                          cmd_is_read,
  input  logic                          read_complete,
  input  logic                          write_complete,
  output logic                          busy,
  output logic [2:0]                    grant_id,
  output logic [31:0]                   cmd_count,
  output logic [15:0]                   err_count
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CPL, ZERO_DONE} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr_ptr, gnt_idx, owner;
  logic hs, cpl, tmo;
  logic [31:0] timer;
  // Scanning downward lets the lowest rotated offset (closest to rr_ptr) win.
  always_comb begin
    gnt_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req_valid[IW'((int'(rr_ptr) + k) % NUM_REQ)]) gnt_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
  end
  assign hs = state == IDLE && |req_valid;
  assign req_ready = hs ? NUM_REQ'(1) << gnt_idx : '0;
  assign cpl = cmd_is_read ? read_complete : write_complete;
  assign tmo = TIMEOUT_CYCLES != 0 && timer == 32'(TIMEOUT_CYCLES - 1);
  assign busy = state != IDLE;
  assign grant_id = 3'(owner);
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = hs ? (req_btt[gnt_idx*32 +: 32] == '0 ? ZERO_DONE : ISSUE) : IDLE;
      ISSUE:    state_d = cmd_ready ? WAIT_CPL : ISSUE;
      WAIT_CPL: state_d = (cpl || tmo) ? IDLE : WAIT_CPL;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      timer <= '0;
      cmd_start <= 1'b0;
      req_done <= '0;
      req_err <= '0;
      cmd_src_addr <= '0;
      cmd_dst_addr <= '0;
      cmd_btt <= '0;
      cmd_is_read <= 1'b1;
      cmd_count <= '0;
      err_count <= '0;
    end else begin
      state <= state_d;
      cmd_start <= state == ISSUE && cmd_ready;
      timer <= state == WAIT_CPL ? timer + 32'd1 : '0;
      req_done <= (state == ZERO_DONE || (state == WAIT_CPL && cpl)) ? NUM_REQ'(1) << owner : '0;
      req_err <= (state == WAIT_CPL && !cpl && tmo) ? NUM_REQ'(1) << owner : '0;
      if (hs) begin
        cmd_src_addr <= req_src_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_dst_addr <= req_dst_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_btt <= req_btt[gnt_idx*32 +: 32];
        cmd_is_read <= req_is_read[gnt_idx];
        owner <= gnt_idx;
        rr_ptr <= gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (state == ISSUE && cmd_ready) cmd_count <= cmd_count + 32'd1;
      if (state == WAIT_CPL && !cpl && tmo && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
endmodule
